country_vehicle_detector: RTL and testbench
===========================================

// Module: country_vehicle_detector
// PURPOSE
//  Vehicle-detector front end for traffic_controller: generates the farm-road request x.
//  Syncs and debounces the raw inductive-loop input, and counts each debounced arrival
//  into a saturating queue counter. Holds x high while any vehicle waits or is served.
//  Reads traffic_controller's country light code and retires one vehicle per
//  PASS_CYCLES clocks of country green.
// PARAMETERS
//  DB_CYCLES   4       consecutive stable synced samples needed to change debounced level (>=2)
//  PASS_CYCLES 3       consecutive country-green clocks that retire one queued vehicle (>=1)
//  CNT_W       4       width of vehicle counter; max count = 2**CNT_W-1
//  GREEN_CODE  3'b001  country light code meaning GREEN
// PORTS
//  clk        in   1      system clock, rising edge
//  start      in   1      async active-low reset; 0 clears all state, 1 = run
//  loop_in    in   1      raw loop sensor, asynchronous, may glitch
//  country    in   3      country light code driven by traffic_controller
//  x          out  1      vehicle request to traffic_controller (registered)
//  car_count  out  CNT_W  vehicles queued/being served (registered)
//  overflow   out  1      sticky: an arrival was dropped at saturation
//  state      out  2      FSM state: 0 IDLE, 1 WAIT, 2 SERVE (3 unused)
// BEHAVIOUR
//  Reset (start=0, async): s1,s2,db,db_cnt,pass_cnt,car_count=0; x=0; overflow=0; state=IDLE.
//  Sync: s1<=loop_in, s2<=s1. Every downstream block uses only s2.
//  Debounce:
//   - s2==db: db_cnt<=0.
//   - s2!=db, db_cnt<DB_CYCLES-1: db_cnt++.
//   - s2!=db, db_cnt==DB_CYCLES-1: db<=s2, db_cnt<=0.
//  arrive = the cycle db goes 0->1 (same edge as db update; no extra stage).
//  depart:
//   - pass_cnt counts edges while country==GREEN_CODE and car_count!=0.
//   - Reaching PASS_CYCLES-1 asserts depart; pass_cnt<=0 on that edge.
//   - pass_cnt<=0 whenever country!=GREEN_CODE or car_count==0.
//  Counter update (car_count_next):
//   - arrive & !depart: +1. At max, value holds and overflow<=1.
//   - depart & !arrive: -1. Never below 0 (depart needs car_count!=0).
//   - arrive & depart: unchanged. overflow not set.
//  Outputs: x<=(car_count_next!=0). x and car_count change on the same edge.
//  Latency: loop_in rises and is held -> x rises on edge DB_CYCLES+2 (edge 6 at default).
//  FSM, evaluated on car_count_next and current country:
//   - IDLE : car_count_next!=0 -> WAIT, or SERVE if country==GREEN_CODE.
//   - WAIT : country==GREEN_CODE -> SERVE. car_count_next==0 -> IDLE.
//   - SERVE: car_count_next==0 -> IDLE. country!=GREEN_CODE (yellow/red) -> WAIT, x stays 1.
//  Green while car_count==0: stay IDLE, x=0, pass_cnt held 0.
//  Country codes other than GREEN_CODE, including illegal codes, are all treated as not-green.
//  Arrivals continue to count during SERVE.
//  start deasserting mid-operation: everything clears immediately, queued vehicles are lost.
//  Vehicles present after reset are detected only on a new debounced rising edge.
// TESTING (defaults; country RED=3'b100 unless stated)
//  1 Reset: start=0, loop_in=1, country=GREEN
//    -> x=0, car_count=0, overflow=0, state=0 throughout; no count after start=1 until edge DB+2.
//  2 Glitch: loop_in high for 3 clocks, then low
//    -> db never rises; car_count=0, x=0.
//  3 Single car: loop_in high 10 clocks, RED -> edge 6: car_count=1, x=1, state=WAIT;
//    then country=GREEN -> state=SERVE; 3 edges later car_count=0, x=0, state=IDLE.
//  4 Saturation: 17 separated pulses (8 high / 8 low each), RED
//    -> car_count=15, overflow=1; overflow stays 1 after later departures.
//  5 Simultaneous: car_count=2, GREEN; arrival debounce completes on the depart edge
//    -> car_count stays 2, x=1, state=SERVE.
//  6 Mid-op reset: car_count=3, SERVE, pass_cnt=1; start=0 between edges
//    -> x, car_count, state clear without waiting for clk; after release, IDLE until new arrival.

Source files
------------

// File: rtl/country_vehicle_detector_if.sv
// Bus between the vehicle detector and the rest of the intersection.
//   loop_in   : raw inductive-loop sensor (asynchronous, may glitch)
//   country   : country light code from traffic_controller
//   x         : vehicle request back to traffic_controller
//   car_count : vehicles queued / being served
//   overflow  : sticky, an arrival was dropped at saturation
//   state     : detector FSM state (0 IDLE, 1 WAIT, 2 SERVE)
// slave = detector side, master = controller/sensor side.
interface country_vehicle_detector_if #(
  parameter int CNT_W = 4
);
  logic             loop_in;
  logic [2:0]       country;
  logic             x;
  logic [CNT_W-1:0] car_count;
  logic             overflow;
  logic [1:0]       state;

  modport slave  (input  loop_in, country, output x, car_count, overflow, state);
  modport master (output loop_in, country, input  x, car_count, overflow, state);
endinterface

// File: rtl/country_vehicle_detector.sv
// Vehicle-detector front end for traffic_controller.
// Synchronises and debounces the loop sensor, counts each debounced arrival
// into a saturating queue counter, retires one vehicle per PASS_CYCLES clocks
// of country green, and raises x while any vehicle is waiting or being served.
// Ports:
//   clk   : system clock, rising edge
//   start : asynchronous active-low reset (0 clears everything, 1 runs)
//   bus   : slave side of country_vehicle_detector_if
module country_vehicle_detector #(
  parameter int         DB_CYCLES   = 4,
  parameter int         PASS_CYCLES = 3,
  parameter int         CNT_W       = 4,
  parameter logic [2:0] GREEN_CODE  = 3'b001
) (
  input logic                        clk,
  input logic                        start,
  country_vehicle_detector_if.slave  bus
);

  localparam int DW = $clog2(DB_CYCLES);
  localparam int PW = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
  localparam logic [DW-1:0]    DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(PASS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SERVE = 2'd2} st_e;

  logic             s1, s2, db;
  logic [DW-1:0]    db_cnt;
  logic [PW-1:0]    pass_cnt;
  logic [CNT_W-1:0] car_count, cnt_nxt;
  logic             x_r, ovf_r, ovf_set;
  st_e              st, st_nxt;
  logic             green, busy, arrive, depart;

  assign green  = (bus.country == GREEN_CODE);
  assign busy   = (car_count != '0);
  // Arrival fires on the edge that flips db 0->1, not a cycle later.
  assign arrive = !db && s2 && (db_cnt == DB_LAST);
  assign depart = green && busy && (pass_cnt == PASS_LAST);

  // Two-flop synchroniser; nothing downstream looks at loop_in or s1.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.loop_in;
      s2 <= s1;
    end
  end

  // Debounce: db follows s2 only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (s2 == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db     <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Green dwell timer; held at zero whenever there is nothing to retire.
  always_ff @(posedge clk or negedge start) begin
    if (!start)                           pass_cnt <= '0;
    else if (!green || !busy || depart)   pass_cnt <= '0;
    else                                  pass_cnt <= pass_cnt + 1'b1;
  end

  // Queue counter next value. A simultaneous arrival and departure cancel.
  always_comb begin
    cnt_nxt = car_count;
    ovf_set = 1'b0;
    if (arrive && !depart) begin
      if (car_count == CNT_MAX) ovf_set = 1'b1;
      else                      cnt_nxt = car_count + 1'b1;
    end else if (depart && !arrive) begin
      cnt_nxt = car_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      car_count <= '0;
      x_r       <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      car_count <= cnt_nxt;
      x_r       <= (cnt_nxt != '0);
      ovf_r     <= ovf_r | ovf_set;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge start) begin
    if (!start) st <= IDLE;
    else        st <= st_nxt;
  end

  // FSM: next state, looks ahead at the counter so state and x move together.
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (cnt_nxt != '0) st_nxt = green ? SERVE : WAIT;
      WAIT:    if (cnt_nxt == '0) st_nxt = IDLE;
               else if (green)    st_nxt = SERVE;
      SERVE:   if (cnt_nxt == '0) st_nxt = IDLE;
               else if (!green)   st_nxt = WAIT;
      default: st_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.state     = st;
    bus.x         = x_r;
    bus.car_count = car_count;
    bus.overflow  = ovf_r;
  end

endmodule

// File: tb/tb_country_vehicle_detector.sv
// Scoreboard bench for country_vehicle_detector: expected snapshots are queued
// as stimulus is applied and popped when the outputs are sampled.
module tb_country_vehicle_detector;
  localparam logic [2:0] GREEN = 3'b001;
  localparam logic [2:0] RED   = 3'b100;

  logic clk = 1'b0;
  logic start;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    string tag;
    int    cnt;
    int    x;
    int    st;
    int    ovf;
  } exp_t;
  exp_t exp_q[$];

  country_vehicle_detector_if #(.CNT_W(4)) bus ();

  country_vehicle_detector #(
    .DB_CYCLES(4), .PASS_CYCLES(3), .CNT_W(4), .GREEN_CODE(GREEN)
  ) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input int cnt, input int x, input int st, input int ovf);
    exp_t e;
    e.tag = tag; e.cnt = cnt; e.x = x; e.st = st; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".cnt"}, int'(bus.car_count), e.cnt);
    chk({e.tag, ".x"},   int'(bus.x),         e.x);
    chk({e.tag, ".st"},  int'(bus.state),     e.st);
    chk({e.tag, ".ovf"}, int'(bus.overflow),  e.ovf);
  endtask

  task automatic do_reset();
    start       = 1'b0;
    bus.loop_in = 1'b0;
    bus.country = RED;
    tick(2);
    start = 1'b1;
    tick(1);
  endtask

  // One separated vehicle: 8 clocks high then 8 low.
  task automatic pulse();
    bus.loop_in = 1'b1;
    tick(8);
    bus.loop_in = 1'b0;
    tick(8);
  endtask

  initial begin
    // 1: reset holds everything clear with loop high and green
    start       = 1'b0;
    bus.loop_in = 1'b1;
    bus.country = GREEN;
    #1;
    push("rst_async", 0, 0, 0, 0); sb_check();
    for (int i = 0; i < 3; i++) begin
      tick(1);
      push("rst_hold", 0, 0, 0, 0); sb_check();
    end
    start = 1'b1;
    tick(5);
    push("rel_e5", 0, 0, 0, 0); sb_check();
    tick(1);
    push("rel_e6", 1, 1, 2, 0); sb_check();

    // 2: 3-clock glitch never makes it through the debouncer
    do_reset();
    bus.loop_in = 1'b1;
    tick(3);
    bus.loop_in = 1'b0;
    tick(10);
    push("glitch", 0, 0, 0, 0); sb_check();

    // 3: single car, wait on red, served on green
    do_reset();
    bus.loop_in = 1'b1;
    tick(5);
    push("car_e5", 0, 0, 0, 0); sb_check();
    tick(1);
    push("car_e6", 1, 1, 1, 0); sb_check();
    tick(4);
    bus.loop_in = 1'b0;
    bus.country = GREEN;
    tick(1);
    push("car_srv", 1, 1, 2, 0); sb_check();
    tick(1);
    push("car_g2", 1, 1, 2, 0); sb_check();
    tick(1);
    push("car_done", 0, 0, 0, 0); sb_check();

    // 4: saturation and sticky overflow
    do_reset();
    for (int i = 0; i < 15; i++) pulse();
    push("sat15", 15, 1, 1, 0); sb_check();
    pulse();
    push("sat16", 15, 1, 1, 1); sb_check();
    pulse();
    push("sat17", 15, 1, 1, 1); sb_check();
    bus.country = GREEN;
    tick(3);
    push("sat_dep", 14, 1, 2, 1); sb_check();

    // 5: arrival completes on the same edge as a departure
    do_reset();
    pulse();
    pulse();
    push("sim_pre", 2, 1, 1, 0); sb_check();
    bus.loop_in = 1'b1;
    tick(3);
    bus.country = GREEN;
    tick(2);
    push("sim_e5", 2, 1, 2, 0); sb_check();
    tick(1);
    push("sim_e6", 2, 1, 2, 0); sb_check();
    tick(3);
    push("sim_e9", 1, 1, 2, 0); sb_check();

    // 6: reset asserted between edges while serving
    do_reset();
    for (int i = 0; i < 3; i++) pulse();
    bus.country = GREEN;
    tick(1);
    push("mid_srv", 3, 1, 2, 0); sb_check();
    #3;
    start = 1'b0;
    #1;
    push("mid_rst", 0, 0, 0, 0); sb_check();
    tick(1);
    start = 1'b1;
    tick(10);
    push("mid_idle", 0, 0, 0, 0); sb_check();
    bus.loop_in = 1'b1;
    tick(6);
    push("mid_new", 1, 1, 2, 0); sb_check();

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
